frame_stack_ctrl: RTL and testbench
===================================

Name: frame_stack_ctrl

Overview:
- Sequences a single-port synchronous stack RAM on behalf of the recursive-Fibonacci controller.
- Each push or pop request moves one whole call frame of FRAME_WORDS words, such as return tag, n and partial result.
- Owns the frame pointer, full/empty tracking and over/underflow rejection.
- Gives the controller a one-shot request / done handshake, so the controller never drives RAM addresses directly.

Parameters:
- WIDTH, 8: bits per stack word.
- FRAME_WORDS, 3: words per frame; must be at least 1.
- DEPTH, 8: capacity in frames. RAM holds DEPTH*FRAME_WORDS words.
- AW, 5: RAM address width; must satisfy 2^AW >= DEPTH*FRAME_WORDS.
- PW, 4: frame-count width; must satisfy 2^PW > DEPTH.

Ports:
- clk, in, 1: clock; all logic is rising-edge.
- rst, in, 1: synchronous, active-high reset.
- push_req, in, 1: one-cycle pulse; request to push push_frame.
- pop_req, in, 1: one-cycle pulse; request to pop one frame.
- push_frame, in, FRAME_WORDS*WIDTH: frame to push. Word i is bits [i*WIDTH +: WIDTH].
- pop_frame, out, FRAME_WORDS*WIDTH: last popped frame, same packing as push_frame.
- busy, out, 1: high while an operation is in progress.
- done, out, 1: one-cycle pulse when an operation finishes.
- err, out, 1: qualified by done; 1 = the operation was rejected.
- count, out, PW: number of frames currently stored.
- full, out, 1: count == DEPTH.
- empty, out, 1: count == 0.
- mem_we, out, 1: RAM write enable.
- mem_re, out, 1: RAM read enable.
- mem_addr, out, AW: RAM address.
- mem_wdata, out, WIDTH: RAM write data.
- mem_rdata, in, WIDTH: RAM read data; valid the cycle after mem_re.

Behaviour:
- Reset values: count=0, empty=1, full=0, busy=0, done=0, err=0, pop_frame=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0; state=IDLE.
- States: IDLE, PUSH, POP_RD, POP_WAIT, REJECT.
- Requests are sampled only in IDLE. A request arriving while busy=1 is ignored: no error, no effect.
- push_frame is captured into an internal register in the accept cycle, so the requester may change it afterwards.
- Arbitration in IDLE:
  - push_req and pop_req together: push wins; the pop is dropped.
  - push_req with full=1, or pop_req with empty=1: go to REJECT.
- REJECT: lasts 1 cycle with done=1, err=1. No RAM access; count unchanged. Then IDLE.
- PUSH (from IDLE on push_req with full=0):
  - Lasts FRAME_WORDS cycles; cycle k (k=0..F-1) has mem_we=1, mem_addr=count*F+k, mem_wdata=captured word k.
  - On the edge ending the last write cycle: count increments, done=1, err=0 in the next cycle (state IDLE).
  - Done therefore appears exactly F+1 cycles after the request cycle.
- POP_RD (from IDLE on pop_req with empty=0):
  - Lasts F cycles; cycle k has mem_re=1, mem_addr=(count-1)*F+k.
  - mem_rdata arriving in the following cycle is stored into pop_frame word k.
- POP_WAIT: 1 cycle; captures the final word into pop_frame and decrements count. Done=1, err=0 in the next cycle.
  - Done therefore appears exactly F+2 cycles after the request cycle.
  - pop_frame is stable from the done cycle until the next pop's first capture.
- busy=1 in PUSH, POP_RD, POP_WAIT, REJECT; busy=0 in IDLE, including the done cycle. A new request may be issued in the done cycle.
- mem_we and mem_re are never high together, and both are 0 in IDLE and REJECT.
- Address arithmetic uses unsigned AW-bit values and never wraps within legal counts.
- Reset during an operation: return to IDLE immediately with reset values and no done pulse. Stored frames are logically discarded (count=0); a partially written frame is never visible.

Test Plan (WIDTH=8, FRAME_WORDS=3, DEPTH=4):
- Reset, then push frame {0x03,0x02,0x01}:
  - mem writes addr 0,1,2 with data 0x01,0x02,0x03 on cycles 1–3.
  - done on cycle 4, err=0, count=1, empty=0.
- Push A={0x13,0x12,0x11}, then push B={0x23,0x22,0x21}, then pop twice:
  - first pop reads addr 3,4,5; done 5 cycles after the request; pop_frame=B.
  - second pop gives pop_frame=A; count=0, empty=1.
- Pop on an empty stack: done+err the next cycle, no mem_re, count stays 0.
- Four pushes give full=1 (last write at addr 11). A fifth push gives done+err, no mem_we, count stays 4.
- push_req and pop_req together with count=1: the push executes (count becomes 2).
- Extra push_req pulses during the busy period are ignored.
- Assert rst on the 2nd write cycle of a push with count=2:
  - next cycle count=0, mem_we=0, no done.
  - a following pop is rejected with err=1.

Source files
------------

// File: rtl/frame_stack_ctrl.sv
// Frame-granular stack sequencer: moves whole call frames between the Fibonacci
// controller and a single-port synchronous stack RAM, one word per cycle.
module frame_stack_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned FRAME_WORDS = 3,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AW          = 5,
    parameter int unsigned PW          = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_req_i,
    input  logic                         pop_req_i,
    input  logic [FRAME_WORDS*WIDTH-1:0] push_frame_i,
    output logic [FRAME_WORDS*WIDTH-1:0] pop_frame_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [PW-1:0]                count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         mem_we_o,
    output logic                         mem_re_o,
    output logic [AW-1:0]                mem_addr_o,
    output logic [WIDTH-1:0]             mem_wdata_o,
    input  logic [WIDTH-1:0]             mem_rdata_i
);

    localparam int unsigned FW = FRAME_WORDS * WIDTH;
    localparam int unsigned KW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [KW-1:0] LastWord = KW'(FRAME_WORDS - 1);
    localparam logic [AW-1:0] FrameA   = AW'(FRAME_WORDS);

    typedef enum logic [2:0] {StIdle, StPush, StPopRd, StPopWait, StReject} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   word_q, word_d;
    logic [PW-1:0]   count_q, count_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [FW-1:0]   pop_frame_q, pop_frame_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic            mem_we_q, mem_we_d;
    logic            mem_re_q, mem_re_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            full, empty;
    logic [FW-1:0]   pop_shift;

    assign full  = (count_q == PW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        // Read words enter at the top and shift down, so word 0 ends up in the low slot.
        pop_shift = pop_frame_q >> WIDTH;
        pop_shift[FW-1 -: WIDTH] = mem_rdata_i;

        state_d     = state_q;
        word_d      = word_q;
        count_d     = count_q;
        frame_d     = frame_q;
        pop_frame_d = pop_frame_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (push_req_i) begin
                    if (full) begin
                        state_d = StReject;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = StPush;
                        word_d      = '0;
                        frame_d     = push_frame_i >> WIDTH;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = AW'(count_q) * FrameA;
                        mem_wdata_d = push_frame_i[WIDTH-1:0];
                    end
                end else if (pop_req_i) begin
                    if (empty) begin
                        state_d = StReject;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = StPopRd;
                        word_d     = '0;
                        mem_re_d   = 1'b1;
                        mem_addr_d = AW'(count_q - PW'(1)) * FrameA;
                    end
                end
            end
            StPush: begin
                if (word_q == LastWord) begin
                    state_d = StIdle;
                    count_d = count_q + PW'(1);
                    done_d  = 1'b1;
                end else begin
                    word_d      = word_q + KW'(1);
                    frame_d     = frame_q >> WIDTH;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q + AW'(1);
                    mem_wdata_d = frame_q[WIDTH-1:0];
                end
            end
            StPopRd: begin
                // Data for the previous read arrives now.
                if (word_q != '0) begin
                    pop_frame_d = pop_shift;
                end
                if (word_q == LastWord) begin
                    state_d = StPopWait;
                end else begin
                    word_d     = word_q + KW'(1);
                    mem_re_d   = 1'b1;
                    mem_addr_d = mem_addr_q + AW'(1);
                end
            end
            StPopWait: begin
                state_d     = StIdle;
                pop_frame_d = pop_shift;
                count_d     = count_q - PW'(1);
                done_d      = 1'b1;
            end
            StReject: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            word_q      <= '0;
            count_q     <= '0;
            frame_q     <= '0;
            pop_frame_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            count_q     <= count_d;
            frame_q     <= frame_d;
            pop_frame_q <= pop_frame_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign pop_frame_o = pop_frame_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_frame_stack_ctrl.sv
// Self-checking bench for frame_stack_ctrl: a queue of frames is the reference stack,
// and a small behavioural RAM with one-cycle read latency serves the DUT.
module tb_frame_stack_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned F  = 3;
    localparam int unsigned D  = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned PW = 4;
    localparam int unsigned FW = F * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_req = 1'b0;
    logic          pop_req = 1'b0;
    logic [FW-1:0] push_frame = '0;
    logic [FW-1:0] pop_frame;
    logic          busy, done, err, full, empty, mem_we, mem_re;
    logic [PW-1:0] count;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;

    logic [W-1:0]  ram [0:(1<<AW)-1];
    logic [FW-1:0] mq [$];
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    frame_stack_ctrl #(
        .WIDTH(W), .FRAME_WORDS(F), .DEPTH(D), .AW(AW), .PW(PW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .push_req_i(push_req), .pop_req_i(pop_req),
        .push_frame_i(push_frame), .pop_frame_o(pop_frame), .busy_o(busy),
        .done_o(done), .err_o(err), .count_o(count), .full_o(full), .empty_o(empty),
        .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic noise_drive(input bit noise);
        push_req   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        pop_req    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        push_frame = FW'($urandom);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 32'(count), mq.size());
        chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, "_full"}, 32'(full), 32'(mq.size() == D));
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // One request; timing and bus activity are checked against the queue model.
    task automatic do_req(input bit p, input bit q, input logic [FW-1:0] f, input bit noise);
        int kind;
        int base;
        logic [FW-1:0] exp;
        @(negedge clk);
        push_req = p; pop_req = q; push_frame = f;
        kind = p ? ((mq.size() == D) ? 2 : 0) : ((mq.size() == 0) ? 2 : 1);
        @(negedge clk);
        noise_drive(noise);
        if (kind == 2) begin
            chk("rej_done", 32'(done), 1);
            chk("rej_err", 32'(err), 1);
            chk("rej_we", 32'(mem_we), 0);
            chk("rej_re", 32'(mem_re), 0);
            chk("rej_count", 32'(count), mq.size());
            @(negedge clk);
            noise_drive(1'b0);
            chk("rej_done_off", 32'(done), 0);
            chk_status("rej");
        end else if (kind == 0) begin
            base = mq.size() * F;
            for (int k = 0; k < F; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    noise_drive(noise);
                end
                chk("push_we", 32'(mem_we), 1);
                chk("push_re", 32'(mem_re), 0);
                chk("push_addr", 32'(mem_addr), base + k);
                chk("push_wdata", 32'(mem_wdata), 32'(f[k*W +: W]));
                chk("push_done_early", 32'(done), 0);
                chk("push_busy", 32'(busy), 1);
            end
            @(negedge clk);
            noise_drive(1'b0);
            mq.push_back(f);
            chk("push_done", 32'(done), 1);
            chk("push_err", 32'(err), 0);
            chk("push_we_off", 32'(mem_we), 0);
            chk_status("push");
        end else begin
            base = (mq.size() - 1) * F;
            for (int k = 0; k < F; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    noise_drive(noise);
                end
                chk("pop_re", 32'(mem_re), 1);
                chk("pop_we", 32'(mem_we), 0);
                chk("pop_addr", 32'(mem_addr), base + k);
                chk("pop_done_early", 32'(done), 0);
            end
            @(negedge clk);
            noise_drive(noise);
            chk("popw_re", 32'(mem_re), 0);
            chk("popw_done", 32'(done), 0);
            chk("popw_busy", 32'(busy), 1);
            @(negedge clk);
            noise_drive(1'b0);
            exp = mq.pop_back();
            chk("pop_done", 32'(done), 1);
            chk("pop_err", 32'(err), 0);
            chk("pop_frame", 32'(pop_frame), 32'(exp));
            chk_status("pop");
        end
    endtask

    initial begin
        logic [FW-1:0] rf;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_pop_frame", 32'(pop_frame), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_re", 32'(mem_re), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);

        do_req(1'b1, 1'b0, 24'h030201, 1'b0);
        do_req(1'b0, 1'b1, '0, 1'b0);
        do_req(1'b1, 1'b0, 24'h131211, 1'b0);
        do_req(1'b1, 1'b0, 24'h232221, 1'b0);
        do_req(1'b0, 1'b1, '0, 1'b0);
        do_req(1'b0, 1'b1, '0, 1'b0);
        do_req(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 5; i++) do_req(1'b1, 1'b0, FW'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) do_req(1'b0, 1'b1, '0, 1'b0);
        do_req(1'b1, 1'b1, 24'h5a5a5a, 1'b0);
        do_req(1'b1, 1'b0, 24'h778899, 1'b1);
        do_req(1'b0, 1'b1, '0, 1'b1);

        // Reset lands on the second write cycle of a push at count 2.
        @(negedge clk);
        push_req = 1'b1; push_frame = 24'hc0ffee;
        @(negedge clk);
        push_req = 1'b0;
        @(negedge clk);
        chk("rstop_we", 32'(mem_we), 1);
        chk("rstop_addr", 32'(mem_addr), 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        chk("rstop_we_off", 32'(mem_we), 0);
        chk("rstop_done", 32'(done), 0);
        chk_status("rstop");
        @(negedge clk);
        chk("rstop_done2", 32'(done), 0);
        do_req(1'b0, 1'b1, '0, 1'b0);

        for (int i = 0; i < 100; i++) begin
            rf = FW'($urandom);
            if ($urandom_range(0, 1) == 1) do_req(1'b1, 1'($urandom_range(0, 1)), rf, 1'($urandom));
            else do_req(1'b0, 1'b1, rf, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
